// File: rtl/pcileech_tx_gearbox_if.sv
// Bus bundle for the TX gearbox: word input side, beat output side, host-idle hint and status.
// The gearbox uses the slave modport; whoever feeds and drains it uses master.
interface pcileech_tx_gearbox_if #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned DEPTH     = 16
);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [IN_WIDTH-1:0]  din;
  logic                 din_valid;
  logic                 din_ready;
  logic [OUT_WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 dout_rd_en;
  logic                 sink_idle;
  logic [LW-1:0]        level;
  logic [15:0]          stat_prefixes;

  modport master (
    output din, din_valid, dout_rd_en, sink_idle,
    input  din_ready, dout, dout_valid, level, stat_prefixes
  );

  modport slave (
    input  din, din_valid, dout_rd_en, sink_idle,
    output din_ready, dout, dout_valid, level, stat_prefixes
  );
endinterface

// File: rtl/pcileech_tx_gearbox.sv
// Word FIFO feeding a width-down serialiser (LSB slice first) for the FT601 path; bursts that start
// after host idle are led by MAGIC_COUNT copies of MAGIC_WORD.
module pcileech_tx_gearbox #(
  parameter int unsigned IN_WIDTH    = 256,
  parameter int unsigned OUT_WIDTH   = 32,
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] MAGIC_WORD  = 32'h66665555,
  parameter int unsigned MAGIC_COUNT = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  pcileech_tx_gearbox_if.slave bus
);
  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = $clog2(DEPTH + 1);
  localparam int unsigned BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned PW    = (MAGIC_COUNT > 1) ? $clog2(MAGIC_COUNT) : 1;

  localparam logic [LW-1:0]        DepthLvl  = LW'(DEPTH);
  localparam logic [BW-1:0]        BeatLast  = BW'(RATIO - 1);
  localparam logic [PW-1:0]        PcntLast  = PW'((MAGIC_COUNT == 0) ? 0 : MAGIC_COUNT - 1);
  localparam logic [OUT_WIDTH-1:0] MagicBeat = OUT_WIDTH'(MAGIC_WORD);
  localparam bit                   PrefixEn  = (MAGIC_COUNT > 0);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || IN_WIDTH < OUT_WIDTH) begin : g_bad_ratio
    $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {StIdle, StPrefix, StData} state_e;

  state_e               state_q;
  logic [IN_WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [LW-1:0]        level_q, level_d;
  logic                 din_ready_q;
  logic                 armed_q;
  logic                 dout_valid_q;
  logic [OUT_WIDTH-1:0] dout_q;
  logic [BW-1:0]        beat_q, beat_inc;
  logic [PW-1:0]        pcnt_q;
  logic [15:0]          stat_q;
  logic                 push, pop;

  logic [RATIO-1:0][OUT_WIDTH-1:0] head_beats, next_beats;

  always_comb begin
    push       = bus.din_valid & din_ready_q;
    pop        = dout_valid_q & bus.dout_rd_en & (state_q == StData) & (beat_q == BeatLast);
    level_d    = level_q + LW'(push) - LW'(pop);
    rd_ptr_nxt = rd_ptr_q + AW'(1);
    beat_inc   = beat_q + BW'(1);
    head_beats = mem_q[rd_ptr_q];
    // Word after the head, so the following word starts without a bubble.
    next_beats = mem_q[rd_ptr_nxt];
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      din_ready_q  <= 1'b0;
      armed_q      <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      beat_q       <= '0;
      pcnt_q       <= '0;
      stat_q       <= '0;
    end else begin
      level_q     <= level_d;
      din_ready_q <= (level_d < DepthLvl);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.sink_idle) begin
            armed_q <= 1'b1;
          end
          // Uses the stored level only; a word being pushed this cycle waits one cycle.
          if (level_q != '0) begin
            dout_valid_q <= 1'b1;
            if (armed_q && PrefixEn) begin
              state_q <= StPrefix;
              armed_q <= 1'b0;
              pcnt_q  <= '0;
              dout_q  <= MagicBeat;
              if (stat_q != 16'hFFFF) begin
                stat_q <= stat_q + 16'd1;
              end
            end else begin
              state_q <= StData;
              beat_q  <= '0;
              dout_q  <= head_beats[0];
            end
          end
        end

        StPrefix: begin
          if (bus.dout_rd_en) begin
            if (pcnt_q == PcntLast) begin
              state_q <= StData;
              beat_q  <= '0;
              dout_q  <= head_beats[0];
            end else begin
              pcnt_q <= pcnt_q + PW'(1);
            end
          end
        end

        StData: begin
          if (bus.dout_rd_en) begin
            if (beat_q != BeatLast) begin
              beat_q <= beat_inc;
              dout_q <= head_beats[beat_inc];
            end else if (level_q > LW'(1)) begin
              beat_q <= '0;
              dout_q <= next_beats[0];
            end else begin
              state_q      <= StIdle;
              dout_valid_q <= 1'b0;
              beat_q       <= '0;
            end
          end
        end

        default: begin
          state_q      <= StIdle;
          dout_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready     = din_ready_q;
  assign bus.dout          = dout_q;
  assign bus.dout_valid    = dout_valid_q;
  assign bus.level         = level_q;
  assign bus.stat_prefixes = stat_q;
endmodule

// File: tb/tb_pcileech_tx_gearbox.sv
// Bench for pcileech_tx_gearbox: directed scenarios plus random traffic against a queue-based model;
// a second instance (64->32, no prefix) is checked against an expected-beat queue.
module tb_pcileech_tx_gearbox;
  localparam logic [31:0] Magic  = 32'h66665555;
  localparam int          RatioA = 8;
  localparam int          McA    = 5;
  localparam int          DepthA = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pcileech_tx_gearbox_if #(.IN_WIDTH(256), .OUT_WIDTH(32), .DEPTH(16)) ifa ();
  pcileech_tx_gearbox_if #(.IN_WIDTH(64), .OUT_WIDTH(32), .DEPTH(4)) ifb ();

  pcileech_tx_gearbox #(
    .IN_WIDTH(256), .OUT_WIDTH(32), .DEPTH(16), .MAGIC_WORD(Magic), .MAGIC_COUNT(5)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );

  pcileech_tx_gearbox #(
    .IN_WIDTH(64), .OUT_WIDTH(32), .DEPTH(4), .MAGIC_WORD(Magic), .MAGIC_COUNT(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // Model of instance A: stored words, presentation status and counters.
  logic [255:0] m_words[$];
  bit           m_valid;
  int           m_prefix_left;
  int           m_beat;
  bit           m_armed;
  bit           m_ready;
  logic [15:0]  m_stat;
  // Beats instance B still owes, in order.
  logic [31:0]  exp_b[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_valid       = 1'b0;
    m_prefix_left = 0;
    m_beat        = 0;
    m_armed       = 1'b1;
    m_ready       = 1'b0;
    m_stat        = '0;
  endtask

  function automatic logic [31:0] model_dout();
    logic [255:0] w;
    if (m_prefix_left > 0) return Magic;
    w = m_words[0];
    return w[m_beat*32 +: 32];
  endfunction

  task automatic model_step();
    bit push, acc, was_idle, armed_old;
    push      = ifa.din_valid && m_ready;
    acc       = m_valid && ifa.dout_rd_en;
    was_idle  = !m_valid;
    armed_old = m_armed;
    if (acc) begin
      if (m_prefix_left > 0) begin
        m_prefix_left--;
      end else if (m_beat < RatioA - 1) begin
        m_beat++;
      end else begin
        void'(m_words.pop_front());
        m_beat = 0;
        if (m_words.size() == 0) m_valid = 1'b0;
      end
    end
    if (was_idle) begin
      if (ifa.sink_idle) m_armed = 1'b1;
      if (m_words.size() > 0) begin
        m_valid = 1'b1;
        m_beat  = 0;
        if (armed_old && McA > 0) begin
          m_prefix_left = McA;
          m_armed       = 1'b0;
          if (m_stat != 16'hFFFF) m_stat++;
        end
      end
    end
    if (push) m_words.push_back(ifa.din);
    m_ready = (m_words.size() < DepthA);
  endtask

  task automatic compare_a();
    check_eq("a_valid", ifa.dout_valid, m_valid);
    if (m_valid) check_eq("a_dout", ifa.dout, model_dout());
    check_eq("a_ready", ifa.din_ready, m_ready);
    check_eq("a_level", ifa.level, m_words.size());
    check_eq("a_stat", ifa.stat_prefixes, m_stat);
  endtask

  // Inputs are set at the falling edge; the model advances on the rising edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_a();
  endtask

  task automatic drive_b(input bit allow_push, input bit force_rd);
    logic [63:0] w;
    w = {$urandom, $urandom};
    ifb.din        = w;
    ifb.din_valid  = allow_push && ($urandom_range(0, 2) == 0);
    ifb.dout_rd_en = force_rd || ($urandom_range(0, 9) < 6);
    if (ifb.dout_valid && ifb.dout_rd_en) begin
      check_eq("b_avail", exp_b.size() > 0, 1'b1);
      if (exp_b.size() > 0) check_eq("b_dout", ifb.dout, exp_b.pop_front());
    end
    if (ifb.din_valid && ifb.din_ready) begin
      exp_b.push_back(w[31:0]);
      exp_b.push_back(w[63:32]);
    end
  endtask

  initial begin
    logic [255:0] w, w1, w2;
    logic [31:0]  stream[$];
    logic [31:0]  exp_s[$];
    int           first_c, last_c, push_pct;
    bit           found;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    ifa.din = '0; ifa.din_valid = 1'b0; ifa.dout_rd_en = 1'b0; ifa.sink_idle = 1'b0;
    ifb.din = '0; ifb.din_valid = 1'b0; ifb.dout_rd_en = 1'b0; ifb.sink_idle = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // T1: reset values, then ready on the first edge after release.
    check_eq("t1_valid", ifa.dout_valid, 1'b0);
    check_eq("t1_dout", ifa.dout, 32'h0);
    check_eq("t1_ready", ifa.din_ready, 1'b0);
    check_eq("t1_level", ifa.level, 0);
    check_eq("t1_stat", ifa.stat_prefixes, 16'h0);
    check_eq("t1_b_valid", ifb.dout_valid, 1'b0);
    rst_n = 1'b1;
    cycle();
    check_eq("t1_ready_up", ifa.din_ready, 1'b1);
    check_eq("t1_level_up", ifa.level, 0);
    check_eq("t1_b_ready_up", ifb.din_ready, 1'b1);

    // T2: armed from reset, one word, continuous read.
    for (int i = 0; i < 32; i++) w[8*i +: 8] = 8'(i + 1);
    ifa.din = w; ifa.din_valid = 1'b1;
    cycle();
    ifa.din_valid  = 1'b0;
    ifa.dout_rd_en = 1'b1;
    stream.delete();
    first_c = -1;
    for (int c = 0; c < 24; c++) begin
      if (ifa.dout_valid) begin
        if (first_c < 0) first_c = c;
        stream.push_back(ifa.dout);
      end
      cycle();
    end
    exp_s.delete();
    for (int k = 0; k < McA; k++) exp_s.push_back(Magic);
    for (int k = 0; k < RatioA; k++) exp_s.push_back(w[32*k +: 32]);
    check_eq("t2_latency", first_c + 1, 2);
    check_eq("t2_count", stream.size(), 13);
    check_eq("t2_first_data", w[31:0], 32'h04030201);
    for (int k = 0; k < 13; k++) check_eq("t2_beat", (k < stream.size()) ? stream[k] : 'x, exp_s[k]);
    check_eq("t2_valid_end", ifa.dout_valid, 1'b0);
    check_eq("t2_stat", ifa.stat_prefixes, 16'd1);

    // T3: not armed, two words back-to-back, no prefix and no gaps.
    w1 = rand256();
    w2 = rand256();
    ifa.din = w1; ifa.din_valid = 1'b1;
    cycle();
    ifa.din = w2;
    cycle();
    ifa.din_valid = 1'b0;
    stream.delete();
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 30; c++) begin
      if (ifa.dout_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        stream.push_back(ifa.dout);
      end
      cycle();
    end
    exp_s.delete();
    for (int k = 0; k < RatioA; k++) exp_s.push_back(w1[32*k +: 32]);
    for (int k = 0; k < RatioA; k++) exp_s.push_back(w2[32*k +: 32]);
    check_eq("t3_count", stream.size(), 16);
    check_eq("t3_span", last_c - first_c, 15);
    for (int k = 0; k < 16; k++) check_eq("t3_beat", (k < stream.size()) ? stream[k] : 'x, exp_s[k]);
    check_eq("t3_stat", ifa.stat_prefixes, 16'd1);

    // T4: fill to DEPTH with no reads, then read and write together.
    ifa.dout_rd_en = 1'b0;
    ifa.sink_idle  = 1'b1;
    repeat (2) cycle();
    for (int i = 0; i < DepthA; i++) begin
      ifa.din = rand256(); ifa.din_valid = 1'b1;
      cycle();
    end
    ifa.din_valid = 1'b0;
    check_eq("t4_ready_full", ifa.din_ready, 1'b0);
    check_eq("t4_level_full", ifa.level, 16);
    ifa.dout_rd_en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      ifa.din = rand256(); ifa.din_valid = m_ready;
      cycle();
    end

    // Random traffic on both instances with varying offered load.
    push_pct = 10;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) push_pct = (c % 300 == 0) ? 3 : ((c % 200 == 0) ? 30 : 10);
      if ($urandom_range(0, 7) == 0) ifa.sink_idle = ~ifa.sink_idle;
      ifa.dout_rd_en = ($urandom_range(0, 9) < 7);
      ifa.din        = rand256();
      ifa.din_valid  = m_ready && ($urandom_range(0, 99) < push_pct);
      drive_b(1'b1, 1'b0);
      cycle();
    end

    // Drain both; T5 expectations for B are its two-beat stream, already checked beat by beat.
    ifa.din_valid  = 1'b0;
    ifa.dout_rd_en = 1'b1;
    for (int c = 0; c < 400 && (m_words.size() != 0 || exp_b.size() != 0 || ifb.dout_valid); c++) begin
      drive_b(1'b0, 1'b1);
      cycle();
    end
    ifb.din_valid = 1'b0;
    check_eq("drain_a_level", ifa.level, 0);
    check_eq("drain_b_left", exp_b.size(), 0);
    check_eq("drain_b_valid", ifb.dout_valid, 1'b0);
    check_eq("drain_b_level", ifb.level, 0);

    // T6: asynchronous reset in the middle of data beat 3, then a fresh prefix.
    ifa.sink_idle  = 1'b1;
    ifa.dout_rd_en = 1'b0;
    repeat (2) cycle();
    ifa.sink_idle = 1'b0;
    ifa.din = rand256(); ifa.din_valid = 1'b1;
    cycle();
    ifa.din_valid  = 1'b0;
    ifa.dout_rd_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (m_valid && m_prefix_left == 0 && m_beat == 3) found = 1'b1;
      else cycle();
    end
    check_eq("t6_reach_beat3", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_valid", ifa.dout_valid, 1'b0);
    check_eq("t6_dout", ifa.dout, 32'h0);
    check_eq("t6_level", ifa.level, 0);
    check_eq("t6_ready", ifa.din_ready, 1'b0);
    check_eq("t6_stat", ifa.stat_prefixes, 16'h0);
    model_reset();
    exp_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    ifa.din = rand256(); ifa.din_valid = 1'b1;
    cycle();
    ifa.din_valid = 1'b0;
    cycle();
    check_eq("t6_prefix_valid", ifa.dout_valid, 1'b1);
    check_eq("t6_prefix_dout", ifa.dout, Magic);
    check_eq("t6_prefix_stat", ifa.stat_prefixes, 16'd1);
    repeat (20) cycle();
    check_eq("t6_done_level", ifa.level, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
